// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer
// (main entry M drives the outputs, skid entry S is younger) and a bubble-making flush.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clock__i,
  input  logic              reset_n__i,
  input  logic              valid__i,
  output logic              ready__o,
  input  logic [CTRL_W-1:0] ctrl__i,
  input  logic [DATA_W-1:0] data__i,
  input  logic              flush__i,
  output logic              valid__o,
  input  logic              ready__i,
  output logic [CTRL_W-1:0] ctrl__o,
  output logic [DATA_W-1:0] data__o,
  output logic [1:0]        occupancy__o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d;
  logic                accept, issue;

  // Outputs decode registered state only, so ready__i/flush__i never reach them combinationally.
  assign valid__o     = (state_q != EMPTY);
  assign ready__o     = (state_q != FULL);
  assign ctrl__o      = valid__o ? m_ctrl_q : '0;
  assign data__o      = m_data_q;
  assign occupancy__o = state_q;

  assign accept = valid__i & ready__o & ~flush__i;
  assign issue  = valid__o & ready__i;

  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          m_ctrl_d = ctrl__i;
          m_data_d = data__i;
        end
      end
      ONE: begin
        if (accept && issue) begin
          m_ctrl_d = ctrl__i;
          m_data_d = data__i;
        end else if (accept) begin
          state_d  = FULL;
          s_ctrl_d = ctrl__i;
          s_data_d = data__i;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (issue) begin
          state_d  = ONE;
          m_ctrl_d = s_ctrl_q;
          m_data_d = s_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over everything: entries become bubbles, payload data is left as is.
    if (flush__i) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
    end
  end

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random run checked
// against a queue model of an in-order two-deep buffer.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 69;
  localparam int unsigned CW = 4;

  logic          clock__i = 1'b0;
  logic          reset_n__i;
  logic          valid__i, ready__o, flush__i, valid__o, ready__i;
  logic [CW-1:0] ctrl__i, ctrl__o;
  logic [DW-1:0] data__i, data__o;
  logic [1:0]    occupancy__o;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clock__i(clock__i), .reset_n__i(reset_n__i),
    .valid__i(valid__i), .ready__o(ready__o), .ctrl__i(ctrl__i), .data__i(data__i),
    .flush__i(flush__i), .valid__o(valid__o), .ready__i(ready__i),
    .ctrl__o(ctrl__o), .data__o(data__o), .occupancy__o(occupancy__o)
  );

  always #5 clock__i = ~clock__i;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t         q[$];
  logic [DW-1:0] out_log[$];
  logic [DW-1:0] last_head;
  bit            acc_last;
  int            checks = 0;
  int            passes = 0;

  // One clock: log what the DUT issues, then advance the reference model.
  task automatic cycle();
    bit    m_acc, m_iss;
    item_t it;
    m_acc = valid__i && (q.size() < 2) && !flush__i;
    m_iss = (q.size() > 0) && ready__i;
    if (valid__o && ready__i) out_log.push_back(data__o);
    @(posedge clock__i);
    #1;
    if (flush__i) q.delete();
    else begin
      if (m_iss) q.delete(0);
      if (m_acc) begin
        it.c = ctrl__i;
        it.d = data__i;
        q.push_back(it);
      end
    end
    if (q.size() > 0) last_head = q[0].d;
    acc_last = m_acc;
  endtask

  task automatic test_reset();
    reset_n__i = 1'b0; valid__i = 1'b0; ready__i = 1'b0; flush__i = 1'b0;
    ctrl__i = '0; data__i = '0;
    q.delete(); last_head = '0;
    #12;
    checks++; if (valid__o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid__o); else passes++;
    checks++; if (ready__o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready__o); else passes++;
    checks++; if (ctrl__o !== '0) $display("FAIL reset_ctrl got=%h exp=0", ctrl__o); else passes++;
    checks++; if (data__o !== '0) $display("FAIL reset_data got=%h exp=0", data__o); else passes++;
    checks++; if (occupancy__o !== 2'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy__o); else passes++;
    @(negedge clock__i); reset_n__i = 1'b1;
    @(posedge clock__i); #1;
    // fill to FULL, then reset asynchronously mid-cycle
    valid__i = 1'b1; ctrl__i = 4'b0110; data__i = DW'(32'h0A); cycle();
    data__i = DW'(32'h0B); cycle();
    valid__i = 1'b0;
    checks++; if (occupancy__o !== 2'd2) $display("FAIL pre_reset_occ got=%0d exp=2", occupancy__o); else passes++;
    #1 reset_n__i = 1'b0;
    #1;
    checks++; if (valid__o !== 1'b0) $display("FAIL async_reset_valid got=%b exp=0", valid__o); else passes++;
    checks++; if (ready__o !== 1'b1) $display("FAIL async_reset_ready got=%b exp=1", ready__o); else passes++;
    checks++; if (occupancy__o !== 2'd0) $display("FAIL async_reset_occ got=%0d exp=0", occupancy__o); else passes++;
    checks++; if (ctrl__o !== '0) $display("FAIL async_reset_ctrl got=%h exp=0", ctrl__o); else passes++;
    checks++; if (data__o !== '0) $display("FAIL async_reset_data got=%h exp=0", data__o); else passes++;
    q.delete(); last_head = '0;
    @(negedge clock__i); reset_n__i = 1'b1;
    @(posedge clock__i); #1;
  endtask

  task automatic test_streaming();
    out_log.delete();
    ready__i = 1'b1; ctrl__i = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      valid__i = 1'b1; data__i = DW'(k);
      cycle();
      checks++; if (valid__o !== 1'b1) $display("FAIL stream_valid item=%0d got=%b exp=1", k, valid__o); else passes++;
      checks++; if (data__o !== DW'(k)) $display("FAIL stream_data got=%0h exp=%0h", data__o, k); else passes++;
      checks++; if (occupancy__o !== 2'd1) $display("FAIL stream_occ item=%0d got=%0d exp=1", k, occupancy__o); else passes++;
      checks++; if (ctrl__o !== 4'b1010) $display("FAIL stream_ctrl got=%b exp=1010", ctrl__o); else passes++;
    end
    valid__i = 1'b0;
    cycle();
    checks++; if (valid__o !== 1'b0) $display("FAIL stream_drain_valid got=%b exp=0", valid__o); else passes++;
    checks++; if (ctrl__o !== '0) $display("FAIL stream_drain_ctrl got=%h exp=0", ctrl__o); else passes++;
    checks++; if (out_log.size() != 8) $display("FAIL stream_count got=%0d exp=8", out_log.size()); else passes++;
    for (int k = 0; k < out_log.size() && k < 8; k++) begin
      checks++; if (out_log[k] !== DW'(k + 1)) $display("FAIL stream_order idx=%0d got=%0h exp=%0h", k, out_log[k], k + 1); else passes++;
    end
  endtask

  task automatic test_back_pressure();
    int nxt = 1;
    int stall = 0;
    bit stalled = 1'b0;
    out_log.delete();
    ctrl__i = 4'b1010;
    for (int cyc = 0; cyc < 40; cyc++) begin
      valid__i = (nxt <= 8); data__i = DW'(nxt);
      if (!stalled && out_log.size() == 3) begin stall = 3; stalled = 1'b1; end
      ready__i = (stall == 0);
      if (stall > 0) stall--;
      cycle();
      if (acc_last) nxt++;
      if (!ready__i && stall == 0) begin
        checks++; if (occupancy__o !== 2'd2) $display("FAIL bp_occ got=%0d exp=2", occupancy__o); else passes++;
        checks++; if (ready__o !== 1'b0) $display("FAIL bp_ready got=%b exp=0", ready__o); else passes++;
        checks++; if (data__o !== DW'(4)) $display("FAIL bp_head got=%0h exp=4", data__o); else passes++;
      end
    end
    valid__i = 1'b0; ready__i = 1'b1;
    checks++; if (occupancy__o !== 2'd0) $display("FAIL bp_drained_occ got=%0d exp=0", occupancy__o); else passes++;
    checks++; if (out_log.size() != 8) $display("FAIL bp_count got=%0d exp=8", out_log.size()); else passes++;
    for (int k = 0; k < out_log.size() && k < 8; k++) begin
      checks++; if (out_log[k] !== DW'(k + 1)) $display("FAIL bp_order idx=%0d got=%0h exp=%0h", k, out_log[k], k + 1); else passes++;
    end
  endtask

  task automatic test_flush_full();
    out_log.delete();
    ready__i = 1'b0; ctrl__i = 4'b1111;
    valid__i = 1'b1; data__i = DW'(32'h10); cycle();
    data__i = DW'(32'h11); cycle();
    checks++; if (occupancy__o !== 2'd2) $display("FAIL flush_pre_occ got=%0d exp=2", occupancy__o); else passes++;
    flush__i = 1'b1; data__i = DW'(32'h12); cycle();
    flush__i = 1'b0; valid__i = 1'b0;
    checks++; if (valid__o !== 1'b0) $display("FAIL flush_valid got=%b exp=0", valid__o); else passes++;
    checks++; if (ctrl__o !== '0) $display("FAIL flush_ctrl got=%h exp=0", ctrl__o); else passes++;
    checks++; if (occupancy__o !== 2'd0) $display("FAIL flush_occ got=%0d exp=0", occupancy__o); else passes++;
    checks++; if (ready__o !== 1'b1) $display("FAIL flush_ready got=%b exp=1", ready__o); else passes++;
    ready__i = 1'b1;
    repeat (3) cycle();
    valid__i = 1'b1; ctrl__i = 4'b0101; data__i = DW'(32'h13); cycle();
    valid__i = 1'b0;
    checks++; if (data__o !== DW'(32'h13) || valid__o !== 1'b1) $display("FAIL flush_next_accept got=%0h/%b exp=13/1", data__o, valid__o); else passes++;
    checks++; if (ctrl__o !== 4'b0101) $display("FAIL flush_next_ctrl got=%b exp=0101", ctrl__o); else passes++;
    cycle();
    checks++; if (out_log.size() != 1 || out_log[0] !== DW'(32'h13)) $display("FAIL flush_issued got=%0d items exp=1 item 13", out_log.size()); else passes++;
  endtask

  task automatic test_accept_issue();
    out_log.delete();
    ready__i = 1'b0; ctrl__i = 4'b0011;
    valid__i = 1'b1; data__i = DW'(32'h20); cycle();
    ready__i = 1'b1; data__i = DW'(32'h21); cycle();
    valid__i = 1'b0; ready__i = 1'b0;
    checks++; if (occupancy__o !== 2'd1) $display("FAIL ai_occ got=%0d exp=1", occupancy__o); else passes++;
    checks++; if (data__o !== DW'(32'h21)) $display("FAIL ai_data got=%0h exp=21", data__o); else passes++;
    checks++; if (out_log.size() != 1 || out_log[0] !== DW'(32'h20)) $display("FAIL ai_issued got=%0d items exp=1 item 20", out_log.size()); else passes++;
    ready__i = 1'b1; cycle(); ready__i = 1'b0;
  endtask

  task automatic test_random();
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
    for (int n = 0; n < 10000; n++) begin
      valid__i = ($urandom_range(3) != 0);
      ready__i = ($urandom_range(2) != 0);
      flush__i = ($urandom_range(49) == 0);
      ctrl__i  = CW'($urandom);
      data__i  = DW'({$urandom, $urandom, $urandom});
      cycle();
      exp_ctrl = (q.size() > 0) ? q[0].c : '0;
      exp_data = (q.size() > 0) ? q[0].d : last_head;
      checks++; if (valid__o !== (q.size() > 0)) $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, valid__o, q.size() > 0); else passes++;
      checks++; if (ready__o !== (q.size() < 2)) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, ready__o, q.size() < 2); else passes++;
      checks++; if (occupancy__o !== 2'(q.size())) $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", n, occupancy__o, q.size()); else passes++;
      checks++; if (ctrl__o !== exp_ctrl) $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", n, ctrl__o, exp_ctrl); else passes++;
      checks++; if (data__o !== exp_data) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", n, data__o, exp_data); else passes++;
    end
    valid__i = 1'b0; flush__i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_accept_issue();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=%0d checks exp=finish", checks);
    $fatal(1, "timeout");
  end

endmodule
